// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode queue bundle: redirect select, fetch-side push handshake,
// decode-side pop handshake and occupancy.
// The queue takes the slave view; the fetch/decode/execute side takes master.
interface fetch_decode_queue_if #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [1:0]       pc_sel;
  logic             f_valid;
  logic [XLEN-1:0]  f_pc;
  logic [ILEN-1:0]  f_instr;
  logic             f_ready;
  logic             d_valid;
  logic [XLEN-1:0]  d_pc;
  logic [ILEN-1:0]  d_instr;
  logic             d_ready;
  logic [CNT_W-1:0] count;

  modport master (
    output pc_sel, f_valid, f_pc, f_instr, d_ready,
    input  f_ready, d_valid, d_pc, d_instr, count
  );

  modport slave (
    input  pc_sel, f_valid, f_pc, f_instr, d_ready,
    output f_ready, d_valid, d_pc, d_instr, count
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: DEPTH-entry in-order FIFO of {pc, instr} between fetch
// and decode. When it is empty, decode sees a NOP bubble (pc 0).
// A redirect (pc_sel 2'b01 / 2'b10) empties the queue and drops the incoming
// fetch entry.
// Optional build macro FETCH_DECODE_QUEUE_BYPASS_EN adds a combinational path
// from fetch to decode. It is used only when the queue is empty and no
// redirect is in progress.
module fetch_decode_queue #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter int              DEPTH     = 2,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013
) (
  input logic                 clk,
  input logic                 rst_n,
  fetch_decode_queue_if.slave q_if
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  // A single-entry queue still needs one pointer bit to index its storage.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

  // Entry storage. These registers have no reset: count_q decides which
  // entries are live.
  logic [XLEN-1:0]  pc_mem_q    [DEPTH];
  logic [ILEN-1:0]  instr_mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             flush_s;
  logic             empty_s;
  logic             f_ready_s;
  logic             byp_s;
  logic             byp_take_s;
  logic             push_s;
  logic             pop_s;
  logic             d_valid_s;
  logic [XLEN-1:0]  d_pc_s;
  logic [ILEN-1:0]  d_instr_s;

  // The pointer wraps from DEPTH-1 to 0, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = PTR_ZERO;
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

  // Decode the redirect select. The reserved code 2'b11 behaves like 2'b00.
  always_comb begin
    flush_s = 1'b0;
    case (q_if.pc_sel)
      2'b01, 2'b10: flush_s = 1'b1;
      2'b00, 2'b11: flush_s = 1'b0;
      default:      flush_s = 1'b0;
    endcase
  end

  // Occupancy status. f_ready depends only on count_q, so there is no path
  // from d_ready. A full queue therefore refuses a push even when it pops in
  // the same cycle.
  always_comb begin
    empty_s   = (count_q == CNT_ZERO);
    f_ready_s = (count_q < CNT_MAX);
  end

  // Bypass qualification. It is active only when the queue is empty, fetch
  // is valid and no redirect is in progress.
  always_comb begin
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
    byp_s      = empty_s && q_if.f_valid && !flush_s;
`else
    byp_s      = 1'b0;
`endif
    byp_take_s = byp_s && q_if.d_ready;
  end

  // Handshake qualification. A redirect cancels both sides. An entry that
  // decode consumes straight from the bypass is never written to storage.
  always_comb begin
    push_s = q_if.f_valid && f_ready_s && !flush_s && !byp_take_s;
    pop_s  = !empty_s && q_if.d_ready && !flush_s;
  end

  // Next-state logic for the pointers and the occupancy counter.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_s) begin
      rd_ptr_d = PTR_ZERO;
      wr_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Decode-side view. The head entry is shown when the queue holds one;
  // otherwise the bypassed fetch entry, otherwise the NOP bubble.
  always_comb begin
    d_valid_s = 1'b0;
    d_pc_s    = {XLEN{1'b0}};
    d_instr_s = NOP_INSTR;
    if (!empty_s) begin
      d_valid_s = 1'b1;
      d_pc_s    = pc_mem_q[rd_ptr_q];
      d_instr_s = instr_mem_q[rd_ptr_q];
    end else if (byp_s) begin
      d_valid_s = 1'b1;
      d_pc_s    = q_if.f_pc;
      d_instr_s = q_if.f_instr;
    end else begin
      d_valid_s = 1'b0;
      d_pc_s    = {XLEN{1'b0}};
      d_instr_s = NOP_INSTR;
    end
  end

  // Control state register, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= PTR_ZERO;
      wr_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_q[wr_ptr_q]    <= q_if.f_pc;
      instr_mem_q[wr_ptr_q] <= q_if.f_instr;
    end
  end

  assign q_if.f_ready = f_ready_s;
  assign q_if.d_valid = d_valid_s;
  assign q_if.d_pc    = d_pc_s;
  assign q_if.d_instr = d_instr_s;
  assign q_if.count   = count_q;

endmodule
